// File: rtl/pattern_seq.sv
// pattern_seq: address sequencer (loop / one-shot / ping-pong) over a writable pattern table,
// emitting either the table word or the raw address.
module pattern_seq #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          PAUSE,
    input  logic [1:0]    MODE,
    input  logic [AW-1:0] LAST,
    input  logic          SEL_IN,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [DW-1:0] WDATA,
    output logic [DW-1:0] OUTDATA,
    output logic [AW-1:0] ADDR,
    output logic          BUSY,
    output logic          DONE,
    output logic          WRAP
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic dir_q, dir_d, wrap_q, wrap_d;
    logic [DW-1:0] table_q [2**AW];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            addr_q <= '0;
            dir_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            dir_q <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 2**AW; i++) table_q[i] <= DW'(i);
        end else if (WE) begin
            table_q[WADDR] <= WDATA;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        dir_d = dir_q;
        wrap_d = 1'b0;
        if (START) begin
            state_d = RUN;
            addr_d = '0;
            dir_d = 1'b0;
        end else if (state_q == RUN && !PAUSE) begin
            if (MODE == 2'b01) begin
                if (addr_q >= LAST) state_d = FIN;
                else addr_d = addr_q + AW'(1);
            end else if (MODE == 2'b10) begin
                if (dir_q) begin
                    if (addr_q <= AW'(1)) begin
                        addr_d = '0;
                        dir_d = 1'b0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end else if (LAST == '0) begin
                    addr_d = '0;
                    wrap_d = 1'b1;
                end else if (addr_q >= LAST) begin
                    // with LAST=1 the turn lands on 0, which is itself the return
                    addr_d = LAST - AW'(1);
                    dir_d = (LAST != AW'(1));
                    wrap_d = (LAST == AW'(1));
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end else begin
                wrap_d = (addr_q >= LAST);
                addr_d = wrap_d ? '0 : addr_q + AW'(1);
            end
        end
    end

    assign OUTDATA = SEL_IN ? DW'(addr_q) : table_q[addr_q];
    assign ADDR = addr_q;
    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign WRAP = wrap_q;
endmodule

// File: tb/tb_pattern_seq.sv
// tb_pattern_seq: scenario tasks for pattern_seq, expectations queued per cycle and popped on sampling.
module tb_pattern_seq;
    localparam int DW = 4;
    localparam int AW = 4;

    logic CLK = 1'b0;
    logic RESET, START, PAUSE, SEL_IN, WE;
    logic [1:0] MODE;
    logic [AW-1:0] LAST, WADDR, ADDR;
    logic [DW-1:0] WDATA, OUTDATA;
    logic BUSY, DONE, WRAP;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic busy;
        logic done;
        logic wrap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pattern_seq #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PAUSE(PAUSE), .MODE(MODE),
        .LAST(LAST), .SEL_IN(SEL_IN), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .OUTDATA(OUTDATA), .ADDR(ADDR), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
    );

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; PAUSE = 1'b0; MODE = 2'b00; LAST = '0;
        SEL_IN = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
        @(negedge CLK);
        checks++;
        if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== 11'b0) begin
            errors++;
            $display("FAIL reset_held got addr=%h data=%h busy=%b done=%b wrap=%b want all 0", ADDR, OUTDATA, BUSY, DONE, WRAP);
        end
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== 11'b0) begin
            errors++;
            $display("FAIL reset_release got addr=%h data=%h busy=%b done=%b wrap=%b want all 0", ADDR, OUTDATA, BUSY, DONE, WRAP);
        end
    endtask

    task automatic test_identity;
        MODE = 2'b00; LAST = 4'd15;
        for (int k = 0; k <= 16; k++) begin
            START = (k == 0);
            sb.push_back('{AW'(k), DW'(k), 1'b1, 1'b0, k == 16});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL identity[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
    endtask

    task automatic test_loop;
        MODE = 2'b00; LAST = 4'd3;
        for (int k = 0; k <= 8; k++) begin
            START = (k == 0);
            sb.push_back('{AW'(k % 4), DW'(k % 4), 1'b1, 1'b0, k > 0 && k % 4 == 0});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL loop[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
    endtask

    task automatic test_oneshot;
        int a;
        MODE = 2'b01; LAST = 4'd5;
        for (int k = 0; k <= 10; k++) begin
            START = (k == 0 || k == 9);
            a = (k >= 9) ? k - 9 : (k > 5 ? 5 : k);
            sb.push_back('{AW'(a), DW'(a), !(k >= 6 && k <= 8), k >= 6 && k <= 8, 1'b0});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL oneshot[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
        START = 1'b0;
    endtask

    task automatic test_pingpong;
        int pp[17] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 0, 0, 0, 0};
        MODE = 2'b10;
        for (int k = 0; k <= 16; k++) begin
            START = (k == 0 || k == 13);
            LAST = (k >= 13) ? 4'd0 : 4'd3;
            sb.push_back('{AW'(pp[k]), DW'(pp[k]), 1'b1, 1'b0, k == 6 || k == 12 || k >= 14});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL pingpong[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
        START = 1'b0;
    endtask

    task automatic test_write_pause;
        int ea[10] = '{0, 1, 2, 2, 2, 2, 3, 0, 1, 2};
        int ed[10] = '{0, 1, 2, 10, 10, 10, 3, 0, 1, 10};
        MODE = 2'b00; LAST = 4'd3;
        for (int k = 0; k <= 9; k++) begin
            START = (k == 0);
            WE = (k == 3); WADDR = 4'd2; WDATA = 4'hA;
            PAUSE = (k >= 3 && k <= 5);
            sb.push_back('{AW'(ea[k]), DW'(ed[k]), 1'b1, 1'b0, k == 7});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL write_pause[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
            if (k == 5) begin
                SEL_IN = 1'b1;
                #1;
                checks++;
                if (OUTDATA !== 4'h2) begin
                    errors++;
                    $display("FAIL sel_addr got %h want 2", OUTDATA);
                end
                SEL_IN = 1'b0;
            end
        end
        WE = 1'b0; PAUSE = 1'b0;
        WADDR = 4'd2; WDATA = 4'h2; WE = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
    endtask

    task automatic test_async_reset;
        MODE = 2'b00; LAST = 4'd15;
        for (int k = 0; k <= 7; k++) begin
            START = (k == 0);
            WE = (k == 1); WADDR = 4'd7; WDATA = 4'd5;
            sb.push_back('{AW'(k), DW'(k == 7 ? 5 : k), 1'b1, 1'b0, 1'b0});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL pre_reset[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
        START = 1'b0; WE = 1'b1; WADDR = 4'd7; WDATA = 4'd9;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset got addr=%h data=%h busy=%b done=%b wrap=%b want all 0", ADDR, OUTDATA, BUSY, DONE, WRAP);
        end
        @(negedge CLK);
        WE = 1'b0; RESET = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            START = (k == 0);
            sb.push_back('{AW'(k), DW'(k), 1'b1, 1'b0, 1'b0});
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({ADDR, OUTDATA, BUSY, DONE, WRAP} !== {e.addr, e.data, e.busy, e.done, e.wrap}) begin
                errors++;
                $display("FAIL post_reset[%0d] got %h/%h/%b%b%b want %h/%h/%b%b%b", k, ADDR, OUTDATA, BUSY, DONE, WRAP, e.addr, e.data, e.busy, e.done, e.wrap);
            end
        end
        START = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_loop();
        test_oneshot();
        test_pingpong();
        test_write_pause();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
